// File: rtl/dvi_rx_decode_if.sv
// Word-rate bus of the DVI receive decoder: raw TMDS words in, decoded video,
// lock status and per-channel alignment offsets out.
interface dvi_rx_decode_if;
    logic [9:0] RX_CH0;
    logic [9:0] RX_CH1;
    logic [9:0] RX_CH2;
    logic [7:0] RX_BLU;
    logic [7:0] RX_GRN;
    logic [7:0] RX_RED;
    logic       RX_HS;
    logic       RX_VS;
    logic       RX_C0;
    logic       RX_C1;
    logic       RX_C2;
    logic       RX_C3;
    logic       RX_DE;
    logic [2:0] RX_LOCK;
    logic [3:0] RX_OFFSET0;
    logic [3:0] RX_OFFSET1;
    logic [3:0] RX_OFFSET2;

    modport master (
        output RX_CH0, RX_CH1, RX_CH2,
        input  RX_BLU, RX_GRN, RX_RED, RX_HS, RX_VS, RX_C0, RX_C1, RX_C2, RX_C3,
        input  RX_DE, RX_LOCK, RX_OFFSET0, RX_OFFSET1, RX_OFFSET2
    );

    modport slave (
        input  RX_CH0, RX_CH1, RX_CH2,
        output RX_BLU, RX_GRN, RX_RED, RX_HS, RX_VS, RX_C0, RX_C1, RX_C2, RX_C3,
        output RX_DE, RX_LOCK, RX_OFFSET0, RX_OFFSET1, RX_OFFSET2
    );
endinterface

// File: rtl/dvi_rx_decode.sv
// TMDS receive decoder: each channel finds its own word boundary by hunting for
// control tokens, then the aligned words are decoded into RGB, sync and DE.
module dvi_rx_decode #(
    parameter bit DVI_RX0   = 1'b0,
    parameter bit DVI_RX1   = 1'b0,
    parameter bit DVI_RX2   = 1'b0,
    parameter int LOCK_CNT  = 32,
    parameter int SEARCH_TO = 4095
) (
    input logic            CLK,
    input logic            RESET,
    dvi_rx_decode_if.slave rx
);
    localparam logic [2:0]  POL      = {DVI_RX2, DVI_RX1, DVI_RX0};
    localparam logic [7:0]  LOCK_LIM = 8'(LOCK_CNT);
    localparam logic [11:0] IDLE_LIM = 12'(SEARCH_TO);
    localparam logic [9:0]  TOK_00   = 10'b1101010100;
    localparam logic [9:0]  TOK_01   = 10'b0010101011;
    localparam logic [9:0]  TOK_10   = 10'b0101010100;
    localparam logic [9:0]  TOK_11   = 10'b1010101011;

    typedef enum logic {ST_SEARCH, ST_LOCKED} state_e;

    logic [2:0][9:0] raw;
    logic [2:0]      is_tok;
    logic [2:0]      locked;
    logic [2:0][1:0] tok_ctl;
    logic [2:0][7:0] dec;
    logic [2:0][3:0] offset;

    assign raw = {rx.RX_CH2, rx.RX_CH1, rx.RX_CH0};

    for (genvar i = 0; i < 3; i++) begin : g_lane
        logic [9:0]  in_r_q, in_r_d, in_rr_q, in_rr_d;
        logic [3:0]  k_q, k_d, k_nxt;
        logic [7:0]  tok_cnt_q, tok_cnt_d;
        logic [11:0] idle_cnt_q, idle_cnt_d;
        state_e      state_q, state_d;
        logic [9:0]  a;
        logic [7:0]  t, d;
        logic        tok;
        logic [1:0]  ctl;

        // in_rr holds the older word, so shifting the 20-bit window right by k
        // walks the boundary forward through the serial bit order.
        always_comb begin
            a   = 10'({in_r_q, in_rr_q} >> k_q);
            tok = 1'b1;
            ctl = 2'b00;
            case (a)
                TOK_00:  ctl = 2'b00;
                TOK_01:  ctl = 2'b01;
                TOK_10:  ctl = 2'b10;
                TOK_11:  ctl = 2'b11;
                default: tok = 1'b0;
            endcase
        end

        always_comb begin
            d    = '0;
            t    = a[9] ? ~a[7:0] : a[7:0];
            d[0] = t[0];
            for (int b = 1; b < 8; b++)
                d[b] = a[8] ? (t[b] ^ t[b-1]) : ~(t[b] ^ t[b-1]);
        end

        always_comb begin
            in_r_d     = raw[i] ^ {10{POL[i]}};
            in_rr_d    = in_r_q;
            k_nxt      = (k_q == 4'd9) ? 4'd0 : k_q + 4'd1;
            state_d    = state_q;
            k_d        = k_q;
            tok_cnt_d  = tok_cnt_q;
            idle_cnt_d = idle_cnt_q;
            case (state_q)
                ST_SEARCH: begin
                    tok_cnt_d  = tok ? tok_cnt_q + 8'd1 : 8'd0;
                    idle_cnt_d = tok ? 12'd0 : idle_cnt_q + 12'd1;
                    if (tok && tok_cnt_d == LOCK_LIM) begin
                        state_d   = ST_LOCKED;
                        tok_cnt_d = '0;
                    end else if (!tok && idle_cnt_d == IDLE_LIM) begin
                        k_d        = k_nxt;
                        tok_cnt_d  = '0;
                        idle_cnt_d = '0;
                    end
                end
                default: begin
                    idle_cnt_d = tok ? 12'd0 : idle_cnt_q + 12'd1;
                    if (!tok && idle_cnt_d == IDLE_LIM) begin
                        state_d    = ST_SEARCH;
                        k_d        = k_nxt;
                        tok_cnt_d  = '0;
                        idle_cnt_d = '0;
                    end
                end
            endcase
        end

        always_ff @(posedge CLK) begin
            if (RESET) begin
                in_r_q     <= '0;
                in_rr_q    <= '0;
                k_q        <= '0;
                tok_cnt_q  <= '0;
                idle_cnt_q <= '0;
                state_q    <= ST_SEARCH;
            end else begin
                in_r_q     <= in_r_d;
                in_rr_q    <= in_rr_d;
                k_q        <= k_d;
                tok_cnt_q  <= tok_cnt_d;
                idle_cnt_q <= idle_cnt_d;
                state_q    <= state_d;
            end
        end

        assign is_tok[i]  = tok;
        assign tok_ctl[i] = ctl;
        assign dec[i]     = d;
        assign locked[i]  = (state_q == ST_LOCKED);
        assign offset[i]  = k_q;
    end

    logic            de_q, de_d;
    logic [2:0][7:0] rgb_q, rgb_d;
    logic [2:0][1:0] ctl_q, ctl_d;

    // Channel 0 decides blanking for all three; control pairs are sticky.
    always_comb begin
        de_d  = 1'b0;
        rgb_d = '0;
        ctl_d = ctl_q;
        if (&locked) begin
            de_d = ~is_tok[0];
            if (!is_tok[0])
                rgb_d = dec;
            for (int i = 0; i < 3; i++)
                if (is_tok[i])
                    ctl_d[i] = tok_ctl[i];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            de_q  <= 1'b0;
            rgb_q <= '0;
            ctl_q <= '0;
        end else begin
            de_q  <= de_d;
            rgb_q <= rgb_d;
            ctl_q <= ctl_d;
        end
    end

    assign rx.RX_BLU     = rgb_q[0];
    assign rx.RX_GRN     = rgb_q[1];
    assign rx.RX_RED     = rgb_q[2];
    assign rx.RX_HS      = ctl_q[0][0];
    assign rx.RX_VS      = ctl_q[0][1];
    assign rx.RX_C0      = ctl_q[1][0];
    assign rx.RX_C1      = ctl_q[1][1];
    assign rx.RX_C2      = ctl_q[2][0];
    assign rx.RX_C3      = ctl_q[2][1];
    assign rx.RX_DE      = de_q;
    assign rx.RX_LOCK    = locked;
    assign rx.RX_OFFSET0 = offset[0];
    assign rx.RX_OFFSET1 = offset[1];
    assign rx.RX_OFFSET2 = offset[2];
endmodule

// File: tb/tb_dvi_rx_decode.sv
// Bench for dvi_rx_decode: directed lock, loss, reset and search steps plus
// randomized token/data traffic compared against a word-level reference model.
module tb_dvi_rx_decode;
    localparam int LOCK_CNT  = 32;
    localparam int SEARCH_TO = 60;
    localparam logic [9:0] TK [4] = '{10'b1101010100, 10'b0010101011,
                                      10'b0101010100, 10'b1010101011};

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    dvi_rx_decode_if bus();

    dvi_rx_decode #(
        .DVI_RX0(1'b0), .DVI_RX1(1'b0), .DVI_RX2(1'b1),
        .LOCK_CNT(LOCK_CNT), .SEARCH_TO(SEARCH_TO)
    ) dut (
        .CLK(CLK), .RESET(RESET), .rx(bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int dly      = 0;
    bit chk      = 1'b0;
    logic [9:0]  carry [3];
    logic [1:0]  mctl  [3];
    logic [29:0] hq [$];

    logic [23:0] rgb_o;
    logic [5:0]  ctl_o;
    logic [11:0] off_o;
    assign rgb_o = {bus.RX_RED, bus.RX_GRN, bus.RX_BLU};
    assign ctl_o = {bus.RX_C3, bus.RX_C2, bus.RX_C1, bus.RX_C0, bus.RX_VS, bus.RX_HS};
    assign off_o = {bus.RX_OFFSET2, bus.RX_OFFSET1, bus.RX_OFFSET0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int tok_idx(input logic [9:0] w);
        for (int j = 0; j < 4; j++)
            if (w == TK[j]) return j;
        return -1;
    endfunction

    // t xor (t<<1) gives the xor-chain; inversion of bits 7:1 when q[8] is low.
    function automatic logic [7:0] dec_ref(input logic [9:0] q);
        logic [7:0] t;
        t = q[9] ? ~q[7:0] : q[7:0];
        return t ^ (t << 1) ^ (q[8] ? 8'h00 : 8'hFE);
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (tok_idx(w) >= 0);
        return w;
    endfunction

    function automatic logic [9:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return TK[$urandom_range(0, 3)];
        return rand_data();
    endfunction

    // Source word w reaches the outputs two edges after the edge that sampled it.
    task automatic model_check(input logic [29:0] w);
        logic [9:0]  q [3];
        logic [23:0] exp_rgb;
        int ti;
        for (int c = 0; c < 3; c++) q[c] = w[c*10 +: 10];
        for (int c = 0; c < 3; c++) begin
            ti = tok_idx(q[c]);
            if (ti >= 0) mctl[c] = 2'(ti);
        end
        ti = tok_idx(q[0]);
        exp_rgb = (ti >= 0) ? 24'd0 : {dec_ref(q[2]), dec_ref(q[1]), dec_ref(q[0])};
        check("model_de",  32'(bus.RX_DE), 32'(ti < 0));
        check("model_rgb", 32'(rgb_o), 32'(exp_rgb));
        check("model_ctl", 32'(ctl_o), 32'({mctl[2], mctl[1], mctl[0]}));
    endtask

    // Serialises source words with a dly-bit lag; channel 2 is sent inverted.
    task automatic step(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
        logic [9:0] s [3];
        logic [9:0] r [3];
        s[0] = s0; s[1] = s1; s[2] = s2;
        for (int c = 0; c < 3; c++) begin
            r[c]     = 10'((20'(s[c]) << dly) | 20'(carry[c]));
            carry[c] = 10'(20'(s[c]) >> (10 - dly));
        end
        bus.RX_CH0 = r[0];
        bus.RX_CH1 = r[1];
        bus.RX_CH2 = ~r[2];
        @(posedge CLK);
        #1;
        hq.push_back({s2, s1, s0});
        if (hq.size() > 3) void'(hq.pop_front());
        if (chk && hq.size() == 3) model_check(hq[0]);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.RX_CH0 = '0;
        bus.RX_CH1 = '0;
        bus.RX_CH2 = 10'h3FF;
        @(posedge CLK);
        #1;
        check("rst_lock", 32'(bus.RX_LOCK), 32'd0);
        check("rst_off",  32'(off_o), 32'd0);
        check("rst_out",  32'({bus.RX_DE, rgb_o, ctl_o}), 32'd0);
        RESET = 1'b0;
        hq.delete();
        for (int c = 0; c < 3; c++) begin
            carry[c] = '0;
            mctl[c]  = '0;
        end
    endtask

    initial begin
        do_reset();

        // Aligned 00 tokens: lock on the 32nd token's edge.
        for (int i = 1; i <= 40; i++) begin
            step(TK[0], TK[0], TK[0]);
            if (i == 33) check("lock_pre", 32'(bus.RX_LOCK), 32'd0);
            if (i == 34) begin
                check("lock_rise", 32'(bus.RX_LOCK), 32'd7);
                chk = 1'b1;
            end
        end
        check("lock_off",  32'(off_o), 32'd0);
        check("lock_sync", 32'({bus.RX_HS, bus.RX_VS, bus.RX_DE}), 32'd0);

        step(10'h100, 10'h2FF, 10'h2FF);
        step(TK[0], TK[0], TK[0]);
        step(TK[0], TK[0], TK[0]);
        check("dir_de",  32'(bus.RX_DE), 32'd1);
        check("dir_rgb", 32'(rgb_o), 32'h00FEFE00);

        step(TK[3], TK[0], TK[0]);
        for (int i = 0; i < 10; i++) step(rand_data(), rand_data(), rand_data());
        check("hsvs_hold", 32'({bus.RX_VS, bus.RX_HS}), 32'd3);

        for (int i = 0; i < 200; i++) step(rnd_word(), rnd_word(), rnd_word());
        for (int i = 0; i < 4; i++) step(TK[0], TK[0], TK[0]);
        chk = 1'b0;

        // Channel 1 starves of tokens and must drop lock after SEARCH_TO words.
        for (int i = 1; i <= 64; i++) begin
            step((i % 8 == 0) ? TK[1] : rand_data(), rand_data(), TK[2]);
            if (i == 61) check("loss_pre", 32'(bus.RX_LOCK), 32'd7);
            if (i == 62) begin
                check("loss_lock", 32'(bus.RX_LOCK), 32'b101);
                check("loss_off1", 32'(bus.RX_OFFSET1), 32'd1);
            end
        end
        check("loss_de",  32'(bus.RX_DE), 32'd0);
        check("loss_rgb", 32'(rgb_o), 32'd0);
        check("loss_ctl", 32'(ctl_o), 32'b100001);

        do_reset();

        // Stream lagging by 3 bits: offsets step 0->1->2->3, then lock there.
        dly = 3;
        for (int i = 1; i <= 3 * SEARCH_TO + 5; i++) begin
            step(10'd0, 10'd0, 10'd0);
            if (i == SEARCH_TO - 1) check("srch_off0", 32'(off_o), 32'h000);
            if (i == SEARCH_TO)     check("srch_off1", 32'(off_o), 32'h111);
            if (i == 2 * SEARCH_TO) check("srch_off2", 32'(off_o), 32'h222);
            if (i == 3 * SEARCH_TO) check("srch_off3", 32'(off_o), 32'h333);
        end
        for (int i = 0; i < 40; i++) step(TK[0], TK[0], TK[0]);
        check("d3_lock", 32'(bus.RX_LOCK), 32'd7);
        check("d3_off",  32'(off_o), 32'h333);
        chk = 1'b1;
        for (int i = 0; i < 150; i++) step(rnd_word(), rnd_word(), rnd_word());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
